// File: rtl/multi_cycle_alu.sv
// Handshaked ALU: single-cycle logic/arith ops plus optional iterative MUL/DIVU
// (enabled by defining MULTI_CYCLE_ALU_MULDIV_EN; otherwise 1000/1001 are illegal).
module multi_cycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               inValid,
    output logic               inReady,
    input  logic [WIDTH-1:0]   inputOne,
    input  logic [WIDTH-1:0]   inputTwo,
    input  logic [3:0]         ALUControl,
    input  logic [SHAMT_W-1:0] shiftAmount,
    output logic               outValid,
    input  logic               outReady,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   resultHi,
    output logic               zero,
    output logic               illegal,
    output logic [1:0]         stateDbg
);

    // Handshake: a request transfers on a rising edge where inValid && inReady;
    // a result transfers where outValid && outReady. Both sides hold until then.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] alu_res;
    logic             alu_illegal;
    logic             is_muldiv;

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (ALUControl)
            4'h0:    alu_res = inputOne + inputTwo;
            4'h1:    alu_res = inputOne - inputTwo;
            4'h2:    alu_res = ~inputOne;
            4'h3:    alu_res = inputOne & inputTwo;
            4'h4:    alu_res = inputOne >> shiftAmount;
            4'h5:    alu_res = inputOne << shiftAmount;
            4'h6:    alu_res = inputOne | inputTwo;
            4'h7:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(inputOne) < $signed(inputTwo))};
            default: alu_illegal = 1'b1;
        endcase
    end

`ifdef MULTI_CYCLE_ALU_MULDIV_EN
    logic [WIDTH-1:0]   b_q, b_d;
    logic               div_q, div_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_rem;
    logic               div_ge;

    assign is_muldiv = (ALUControl == 4'h8) || (ALUControl == 4'h9);

    // {hi,lo} is the shift-add product register for MUL and {remainder,quotient}
    // for restoring DIVU; a zero divisor naturally yields all-ones and rem = A.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_rem   = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            b_q   <= b_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end
`else
    assign is_muldiv = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        illegal_d = illegal_q;
`ifdef MULTI_CYCLE_ALU_MULDIV_EN
        b_d       = b_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    hi_d = '0;
                    if (is_muldiv) begin
                        state_d   = BUSY;
                        lo_d      = inputOne;
                        illegal_d = 1'b0;
`ifdef MULTI_CYCLE_ALU_MULDIV_EN
                        b_d       = inputTwo;
                        div_d     = ALUControl[0];
                        cnt_d     = SHAMT_W'(WIDTH - 1);
`endif
                    end else begin
                        state_d   = DONE;
                        lo_d      = alu_res;
                        illegal_d = alu_illegal;
                    end
                end
            end
            BUSY: begin
`ifdef MULTI_CYCLE_ALU_MULDIV_EN
                if (div_q) begin
                    hi_d = div_rem[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end else begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (outReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            illegal_q <= illegal_d;
        end
    end

    assign inReady  = (state_q == IDLE);
    assign outValid = (state_q == DONE);
    assign result   = lo_q;
    assign resultHi = hi_q;
    assign zero     = outValid && (lo_q == '0);
    assign illegal  = outValid && illegal_q;
    assign stateDbg = state_q;

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Bench for multi_cycle_alu (WIDTH=32): vector table, random ops against a
// plain-arithmetic model, DONE back-pressure and reset-abort sequences.
module tb_multi_cycle_alu;

    localparam int W = 32;
`ifdef MULTI_CYCLE_ALU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetN;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  inputOne;
    logic [W-1:0]  inputTwo;
    logic [3:0]    ALUControl;
    logic [4:0]    shiftAmount;
    logic          outValid;
    logic          outReady;
    logic [W-1:0]  result;
    logic [W-1:0]  resultHi;
    logic          zero;
    logic          illegal;
    logic [1:0]    stateDbg;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   sh;
        logic [W-1:0] r;
        logic [W-1:0] h;
        logic         ill;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    multi_cycle_alu #(.WIDTH(W)) dut (
        .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady),
        .inputOne(inputOne), .inputTwo(inputTwo), .ALUControl(ALUControl),
        .shiftAmount(shiftAmount), .outValid(outValid), .outReady(outReady),
        .result(result), .resultHi(resultHi), .zero(zero), .illegal(illegal),
        .stateDbg(stateDbg)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [4:0] sh, output logic [W-1:0] r, output logic [W-1:0] h,
                                  output logic ill, output int lat);
        longint unsigned p;
        r = '0; h = '0; ill = 1'b0; lat = 1;
        case (op)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = ~a;
            4'h3: r = a & b;
            4'h4: r = a >> sh;
            4'h5: r = a << sh;
            4'h6: r = a | b;
            4'h7: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'h8: if (MULDIV) begin
                      p = longint'(a) * longint'(b);
                      r = p[31:0]; h = p[63:32]; lat = W + 1;
                  end else ill = 1'b1;
            4'h9: if (MULDIV) begin
                      lat = W + 1;
                      if (b == 0) begin r = '1; h = a; end
                      else begin r = a / b; h = a % b; end
                  end else ill = 1'b1;
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] sh, input logic [W-1:0] er,
                          input logic [W-1:0] eh, input logic eill, input int elat);
        int n;
        int hold;
        logic [2*W-1:0] e;
        exp_q.push_back({eh, er});
        @(negedge clk);
        inValid = 1'b1; ALUControl = op; inputOne = a; inputTwo = b; shiftAmount = sh; outReady = 1'b0;
        n = 0;
        while (!inReady && n < 100) begin @(negedge clk); n++; end
        check({tag, " accept"}, 64'(inReady), 64'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0; inputOne = $urandom; inputTwo = $urandom;
        ALUControl = 4'($urandom); shiftAmount = 5'($urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (!outValid && n < 100);
        check({tag, " latency"}, 64'(n), 64'(elat));
        e = exp_q.pop_front();
        check({tag, " result"}, 64'(result), 64'(e[W-1:0]));
        check({tag, " resultHi"}, 64'(resultHi), 64'(e[2*W-1:W]));
        check({tag, " zero"}, 64'(zero), 64'(e[W-1:0] == 0));
        check({tag, " illegal"}, 64'(illegal), 64'(eill));
        hold = $urandom_range(0, 3);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold"}, {31'd0, outValid, result}, {31'd1, e[W-1:0]});
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        check({tag, " release"}, {61'd0, outValid, zero, illegal}, 64'd0);
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [4:0] sh, input logic [W-1:0] r, input logic [W-1:0] h,
                                input logic ill, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sh = sh; v.r = r; v.h = h; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    initial begin
        int n;
        int seen;
        logic [3:0]   op;
        logic [W-1:0] a, b, r, h;
        logic [4:0]   sh;
        logic         ill;
        int           lat;

        vecs.push_back(mk(4'h0, 4, 8, 0, 12, 0, 0, 1));
        vecs.push_back(mk(4'h7, 17, 2, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'h7, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(4'h4, 10, 0, 2, 2, 0, 0, 1));
        vecs.push_back(mk(4'h1, 3, 5, 0, 32'hFFFF_FFFE, 0, 0, 1));
        vecs.push_back(mk(4'h2, 0, 7, 0, 32'hFFFF_FFFF, 0, 0, 1));
        vecs.push_back(mk(4'h5, 1, 0, 31, 32'h8000_0000, 0, 0, 1));
        vecs.push_back(mk(4'h3, 32'hF0F0, 32'hFF00, 0, 32'hF000, 0, 0, 1));
        vecs.push_back(mk(4'h6, 32'hF0F0, 32'hFF00, 0, 32'hFFF0, 0, 0, 1));
        vecs.push_back(mk(4'h0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'hF, 5, 6, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'hA, 5, 6, 0, 0, 0, 1, 1));
        if (MULDIV) begin
            vecs.push_back(mk(4'h8, 32'hFFFF_FFFF, 2, 0, 32'hFFFF_FFFE, 1, 0, 33));
            vecs.push_back(mk(4'h9, 100, 7, 0, 14, 2, 0, 33));
            vecs.push_back(mk(4'h9, 5, 0, 0, 32'hFFFF_FFFF, 5, 0, 33));
            vecs.push_back(mk(4'h8, 3, 4, 0, 12, 0, 0, 33));
        end else begin
            vecs.push_back(mk(4'h8, 3, 4, 0, 0, 0, 1, 1));
            vecs.push_back(mk(4'h9, 100, 7, 0, 0, 0, 1, 1));
        end

        resetN = 1'b0; inValid = 1'b0; outReady = 1'b0;
        inputOne = '0; inputTwo = '0; ALUControl = '0; shiftAmount = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {inReady, outValid, zero, illegal, result, resultHi}, {4'b1000, 64'd0});
        resetN = 1'b1;
        @(negedge clk);
        check("post-reset ready", {62'd0, inReady, outValid}, 64'b10);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
                   vecs[i].r, vecs[i].h, vecs[i].ill, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom >> $urandom_range(0, 31));
            sh = 5'($urandom);
            model(op, a, b, sh, r, h, ill, lat);
            run_op($sformatf("rand%0d op%0h", i, op), op, a, b, sh, r, h, ill, lat);
        end

        // DONE back-pressure: result must hold and a waiting request must stay out.
        @(negedge clk);
        inValid = 1'b1; ALUControl = 4'h0; inputOne = 4; inputTwo = 8; outReady = 1'b0;
        @(posedge clk);
        #1;
        ALUControl = 4'h1; inputOne = 9; inputTwo = 3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d", i), {30'd0, outValid, inReady, result}, {30'd0, 2'b10, 32'd12});
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        check("stall release", {62'd0, outValid, inReady}, 64'b01);
        @(negedge clk);
        inValid = 1'b0;
        check("queued sub", {31'd0, outValid, result}, {31'd1, 32'd6});
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;

        // Reset at BUSY cycle 12 of a multiply aborts it.
        inValid = 1'b1; ALUControl = 4'h8; inputOne = 123; inputTwo = 456;
        n = 0;
        while (!inReady && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (12) @(negedge clk);
        check("mul busy", 64'(outValid), MULDIV ? 64'd0 : 64'd1);
        resetN = 1'b0;
        #1;
        check("abort async", {inReady, outValid, result}, {2'b10, 32'd0});
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (outValid) seen++;
        end
        check("abort no result", 64'(seen), 64'd0);
        check("abort ready", 64'(inReady), 64'd1);
        run_op("after abort add", 4'h0, 4, 8, 0, 12, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
